// File: rtl/column_sum_pkg.sv
// Shared types and defaults for the column-sum controller and datapath.
// State encoding plus a column-index width helper.
package column_sum_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TERMS_DEF  = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    ACCUM = 3'd2,
    CHECK = 3'd3,
    WRITE = 3'd4,
    ERR   = 3'd5
  } state_t;

  function automatic int col_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/column_sum_result_reg.sv
// Holding register for one column sum and its index.
// Presents the held value on a valid/ready port until accepted.
module column_sum_result_reg
  import column_sum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int COL_W  = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              capture,
  input  logic [DATA_W-1:0] data_in,
  input  logic [COL_W-1:0]  col_in,
  input  logic              set_valid,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [COL_W-1:0]  col,
  output logic              valid,
  output logic              fire
);

  assign fire = valid & ready;

  // Capture the sum on request; valid rises on request, falls on handshake.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data  <= '0;
      col   <= '0;
      valid <= 1'b0;
    end else begin
      if (capture) begin
        data <= data_in;
        col  <= col_in;
      end
      if (set_valid) begin
        valid <= 1'b1;
      end else if (fire) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/column_sum_controller.sv
// Sequencer for the column-sum datapath: fetch, accumulate, check, emit.
// Cross-checks the datapath term counter and reports desync as ERR.
module column_sum_controller
  import column_sum_pkg::*;
#(
  parameter  int DATA_W   = DATA_W_DEF,
  parameter  int NUM_COLS = 8,
  parameter  int TERMS    = TERMS_DEF,
  localparam int COL_W    = col_width(NUM_COLS)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [COL_W-1:0]  col_addr,
  output logic              fetch_req,
  input  logic              fetch_valid,
  output logic              dp_clr,
  output logic              load_sum,
  input  logic              done_iter,
  input  logic [DATA_W-1:0] sum_out,
  output logic [DATA_W-1:0] result_data,
  output logic [COL_W-1:0]  result_col,
  output logic              result_valid,
  input  logic              result_ready
);

  localparam int K_W = $clog2(TERMS + 1);
  localparam logic [K_W-1:0]   K_LAST   = K_W'(TERMS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(NUM_COLS - 1);

  state_t           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [K_W-1:0]   k_q, k_d;
  logic             done_q, done_d;
  logic             capture, set_valid, fire;

  // State, column index, term count and done pulse registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      col_q   <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      k_q     <= k_d;
      done_q  <= done_d;
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    k_d       = k_q;
    done_d    = 1'b0;
    dp_clr    = 1'b1;
    fetch_req = 1'b0;
    load_sum  = 1'b0;
    capture   = 1'b0;
    set_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          col_d   = '0;
        end
      end
      FETCH: begin
        fetch_req = 1'b1;
        if (fetch_valid) begin
          state_d = ACCUM;
          k_d     = '0;
        end
      end
      ACCUM: begin
        dp_clr   = 1'b0;
        load_sum = 1'b1;
        if (done_iter && (k_q != K_LAST)) begin
          state_d = ERR;
        end else if (k_q == K_LAST) begin
          capture = 1'b1;
          state_d = CHECK;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      CHECK: begin
        dp_clr = 1'b0;
        if (done_iter) begin
          set_valid = 1'b1;
          state_d   = WRITE;
        end else begin
          state_d = ERR;
        end
      end
      WRITE: begin
        if (fire) begin
          if (col_q == COL_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            col_d   = col_q + COL_W'(1);
            state_d = FETCH;
          end
        end
      end
      ERR: begin
        if (start) begin
          state_d = FETCH;
          col_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = (state_q != IDLE) && (state_q != ERR);
  assign error    = (state_q == ERR);
  assign done     = done_q;
  assign col_addr = col_q;

  column_sum_result_reg #(
    .DATA_W (DATA_W),
    .COL_W  (COL_W)
  ) u_result (
    .clk       (clk),
    .clr       (clr),
    .capture   (capture),
    .data_in   (sum_out),
    .col_in    (col_q),
    .set_valid (set_valid),
    .ready     (result_ready),
    .data      (result_data),
    .col       (result_col),
    .valid     (result_valid),
    .fire      (fire)
  );

endmodule
